spi_slave_seq: RTL

Autonomous sequencer for the 8-bit SPI slave core's register port. It moves bytes between two byte-wide streaming FIFOs (TX and RX) and the slave's data registers, so fabric logic can exchange SPI traffic without a CPU. It sits between fabric stream producers/consumers and the slave core's `spi_select`/`mem_addr`/`read_n`/`write_n` port, and optionally monitors and clears its error flags.

---
 rtl/spi_slave_seq_if.sv | 36 +++
 rtl/spi_slave_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_seq_if.sv
// spi_slave_seq_if: groups the stream FIFO handshakes, the SPI slave
// register port and the error-flag signals of the spi_slave_seq sequencer.
// The master modport is the sequencer's view; slave is the surrounding fabric.
interface spi_slave_seq_if;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic        read_n;
    logic        write_n;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        dataavailable;
    logic        readyfordata;
    logic        err_roe;
    logic        err_toe;
    logic        err_clr;

    modport master (
        input  tx_data, tx_valid, rx_ready, data_to_cpu, dataavailable,
               readyfordata, err_clr,
        output tx_ready, rx_data, rx_valid, spi_select, mem_addr, read_n,
               write_n, data_from_cpu, err_roe, err_toe
    );

    modport slave (
        output tx_data, tx_valid, rx_ready, data_to_cpu, dataavailable,
               readyfordata, err_clr,
        input  tx_ready, rx_data, rx_valid, spi_select, mem_addr, read_n,
               write_n, data_from_cpu, err_roe, err_toe
    );
endinterface

// File: rtl/spi_slave_seq.sv
// spi_slave_seq: moves bytes between a TX stream FIFO, an RX stream FIFO and
// the data registers of an 8-bit SPI slave core through its register port.
// Every slave access is A1 + A2 (strobe held) followed by one GAP cycle.
// Optional feature macro: SPI_SEQ_ERRMON_EN (periodic status poll, sticky
// err_roe/err_toe and clearing of the slave's error flags).
module spi_slave_seq #(
    parameter int FIFO_AW     = 4,
    parameter int STAT_PERIOD = 256
) (
    input  logic           clk,
    input  logic           reset_n,
    spi_slave_seq_if.master bus
);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [3:0] INIT   = 4'd0;
    localparam logic [3:0] IDLE   = 4'd1;
    localparam logic [3:0] RD_A1  = 4'd2;
    localparam logic [3:0] RD_A2  = 4'd3;
    localparam logic [3:0] WR_A1  = 4'd4;
    localparam logic [3:0] WR_A2  = 4'd5;
    localparam logic [3:0] ST_A1  = 4'd6;
    localparam logic [3:0] ST_A2  = 4'd7;
    localparam logic [3:0] CLR_A1 = 4'd8;
    localparam logic [3:0] CLR_A2 = 4'd9;
    localparam logic [3:0] GAP    = 4'd10;

    logic [3:0]       state_q, state_d;
    logic             sel_q, sel_d;
    logic [2:0]       addr_q, addr_d;
    logic             rdn_q, rdn_d;
    logic             wrn_q, wrn_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [FIFO_AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [FIFO_AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [7:0]       tx_mem_q [DEPTH];
    logic [7:0]       rx_mem_q [DEPTH];

    logic tx_full, tx_empty, tx_push, tx_pop;
    logic rx_full, rx_empty, rx_push, rx_pop;
    logic poll_due, clr_pend;
    logic unused_hi;

    assign tx_full  = (tx_wp_q[FIFO_AW] != tx_rp_q[FIFO_AW]) &&
                      (tx_wp_q[FIFO_AW-1:0] == tx_rp_q[FIFO_AW-1:0]);
    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign rx_full  = (rx_wp_q[FIFO_AW] != rx_rp_q[FIFO_AW]) &&
                      (rx_wp_q[FIFO_AW-1:0] == rx_rp_q[FIFO_AW-1:0]);
    assign rx_empty = (rx_wp_q == rx_rp_q);

    // A pop at the WR_A2 edge frees a slot, so a full TX FIFO still accepts then.
    assign tx_pop        = (state_q == WR_A2);
    assign bus.tx_ready  = !tx_full || tx_pop;
    assign tx_push       = bus.tx_valid && bus.tx_ready;
    assign rx_push       = (state_q == RD_A2);
    assign bus.rx_valid  = !rx_empty;
    assign rx_pop        = bus.rx_valid && bus.rx_ready;
    assign bus.rx_data   = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q[FIFO_AW-1:0]];

    assign bus.spi_select    = sel_q;
    assign bus.mem_addr      = addr_q;
    assign bus.read_n        = rdn_q;
    assign bus.write_n       = wrn_q;
    assign bus.data_from_cpu = wdata_q;
    assign unused_hi         = ^bus.data_to_cpu[15:8];

`ifdef SPI_SEQ_ERRMON_EN
    logic [15:0] stat_cnt_q, stat_cnt_d;
    logic        clr_pend_q, clr_pend_d;
    logic        err_roe_q, err_roe_d;
    logic        err_toe_q, err_toe_d;

    assign poll_due    = (stat_cnt_q == 16'd0);
    assign clr_pend    = clr_pend_q;
    assign bus.err_roe = err_roe_q;
    assign bus.err_toe = err_toe_q;

    // Poll countdown, pending-clear request and sticky error flags (clear wins).
    always_comb begin
        stat_cnt_d = stat_cnt_q;
        clr_pend_d = clr_pend_q;
        err_roe_d  = err_roe_q;
        err_toe_d  = err_toe_q;
        if (state_q == ST_A2) begin
            stat_cnt_d = 16'(STAT_PERIOD);
            clr_pend_d = bus.data_to_cpu[3] || bus.data_to_cpu[4];
            err_roe_d  = err_roe_q || bus.data_to_cpu[3];
            err_toe_d  = err_toe_q || bus.data_to_cpu[4];
        end else if (state_q == IDLE && stat_cnt_q != 16'd0) begin
            stat_cnt_d = stat_cnt_q - 16'd1;
        end
        if (state_q == GAP && clr_pend_q) begin
            clr_pend_d = 1'b0;
        end
        if (bus.err_clr) begin
            err_roe_d = 1'b0;
            err_toe_d = 1'b0;
        end
    end

    // Error-monitor registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_cnt_q <= 16'(STAT_PERIOD);
            clr_pend_q <= 1'b0;
            err_roe_q  <= 1'b0;
            err_toe_q  <= 1'b0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
            clr_pend_q <= clr_pend_d;
            err_roe_q  <= err_roe_d;
            err_toe_q  <= err_toe_d;
        end
    end
`else
    logic [16:0] unused_cfg;

    assign poll_due    = 1'b0;
    assign clr_pend    = 1'b0;
    assign bus.err_roe = 1'b0;
    assign bus.err_toe = 1'b0;
    assign unused_cfg  = {bus.err_clr, 16'(STAT_PERIOD)};
`endif

    // FIFO pointer updates for both stream FIFOs.
    always_comb begin
        tx_wp_d = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
        tx_rp_d = tx_pop  ? tx_rp_q + 1'b1 : tx_rp_q;
        rx_wp_d = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
        rx_rp_d = rx_pop  ? rx_rp_q + 1'b1 : rx_rp_q;
    end

    // Sequencer: arbitration in IDLE, then registered bus outputs for A1/A2/GAP.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        rdn_d   = rdn_q;
        wrn_d   = wrn_q;
        wdata_d = wdata_q;
        case (state_q)
            INIT: begin
                state_d = CLR_A1;
                sel_d   = 1'b1;
                addr_d  = 3'd3;
                wrn_d   = 1'b0;
                wdata_d = 16'h0000;
            end
            IDLE: begin
                if (poll_due) begin
                    state_d = ST_A1;
                    sel_d   = 1'b1;
                    addr_d  = 3'd2;
                    rdn_d   = 1'b0;
                    wdata_d = 16'h0000;
                end else if (bus.dataavailable && !rx_full) begin
                    state_d = RD_A1;
                    sel_d   = 1'b1;
                    addr_d  = 3'd0;
                    rdn_d   = 1'b0;
                    wdata_d = 16'h0000;
                end else if (bus.readyfordata && !tx_empty) begin
                    state_d = WR_A1;
                    sel_d   = 1'b1;
                    addr_d  = 3'd1;
                    wrn_d   = 1'b0;
                    wdata_d = {8'h00, tx_mem_q[tx_rp_q[FIFO_AW-1:0]]};
                end
            end
            RD_A1:  state_d = RD_A2;
            WR_A1:  state_d = WR_A2;
            ST_A1:  state_d = ST_A2;
            CLR_A1: state_d = CLR_A2;
            RD_A2, WR_A2, ST_A2, CLR_A2: begin
                state_d = GAP;
                sel_d   = 1'b0;
                rdn_d   = 1'b1;
                wrn_d   = 1'b1;
            end
            GAP: begin
                if (clr_pend) begin
                    state_d = CLR_A1;
                    sel_d   = 1'b1;
                    addr_d  = 3'd2;
                    wrn_d   = 1'b0;
                    wdata_d = 16'h0000;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 1'b0;
                rdn_d   = 1'b1;
                wrn_d   = 1'b1;
            end
        endcase
    end

    // State, bus output and FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= INIT;
            sel_q   <= 1'b0;
            addr_q  <= 3'd0;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            wdata_q <= 16'h0000;
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            rdn_q   <= rdn_d;
            wrn_q   <= wrn_d;
            wdata_q <= wdata_d;
            tx_wp_q <= tx_wp_d;
            tx_rp_q <= tx_rp_d;
            rx_wp_q <= rx_wp_d;
            rx_rp_q <= rx_rp_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wp_q[FIFO_AW-1:0]] <= bus.tx_data;
        end
        if (rx_push) begin
            rx_mem_q[rx_wp_q[FIFO_AW-1:0]] <= bus.data_to_cpu[7:0];
        end
    end
endmodule
